mux2_1_arbiter: RTL
===================

Name: mux2_1_arbiter

Overview:
- Round-robin, packet-locked arbiter that shares one output channel between two requesters.
- Sequences a WIDTH-bit bank of mux2_1 cells by driving their common select.
- Requester 1 maps to the mux "one" input; requester 0 maps to the "zero" input.
- Sits between two stream sources and a single sink. Provides per-requester packet counters for status.

Parameters:
- WIDTH, 8, data width of each requester and of the output.
- CNT_W, 8, width of each per-requester completed-packet counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  one clock; reset is asynchronous and active-high.
- in0_valid  input  1  requester 0 has a beat.
- in0_data  input  WIDTH  requester 0 beat data.
- in0_last  input  1  requester 0 beat is the final beat of its packet.
- in0_ready  output  1  requester 0 beat accepted this cycle when in0_valid is also high.
- in1_valid  input  1  requester 1 has a beat.
- in1_data  input  WIDTH  requester 1 beat data.
- in1_last  input  1  requester 1 final beat.
- in1_ready  output  1  requester 1 beat accepted when in1_valid is also high.
- out_valid  output  1  beat presented to the sink.
- out_data  output  WIDTH  muxed data.
- out_last  output  1  muxed last flag.
- out_ready  input  1  sink accepts the beat.
- grant  output  2  one-hot current owner: 01 = requester 0, 10 = requester 1, 00 = idle.
- pkt_cnt0  output  CNT_W  packets completed by requester 0.
- pkt_cnt1  output  CNT_W  packets completed by requester 1.

Behaviour:
- FSM states: IDLE, GNT0, GNT1. State, priority pointer `prio` and the counters are registered. Datapath is combinational through the mux bank.
- Reset (async assert, at any time including mid-packet):
  - state = IDLE, prio = 0 (requester 0 preferred), pkt_cnt0 = pkt_cnt1 = 0.
  - grant = 00, out_valid = 0, in0_ready = in1_ready = 0.
  - out_data and out_last = 0 (select = 0, gated by the idle state).
  - The packet in flight is abandoned. No recovery or replay.
- IDLE:
  - All readys and out_valid are 0.
  - Only in0_valid high -> GNT0 next cycle.
  - Only in1_valid high -> GNT1 next cycle.
  - Both high -> GNT(prio).
  - Neither high -> stay in IDLE.
  - First-beat latency from IDLE is 1 cycle; the grant is registered and nothing passes in the decision cycle.
- GNTn:
  - select = n.
  - out_valid = inN_valid, out_data = inN_data, out_last = inN_last.
  - inN_ready = out_ready; the other requester's ready = 0.
  - A beat transfers when inN_valid & out_ready.
  - Ownership holds across beats, including cycles where inN_valid drops mid-packet. No timeout.
- Packet end (transfer with inN_last = 1):
  - pkt_cntN increments, wrapping modulo 2^CNT_W.
  - prio becomes the other requester.
  - Next state is GNT(other) if the other requester's valid is high in that cycle (zero-bubble handoff). Otherwise IDLE.
  - The same requester never retains the grant directly; it re-arbitrates via IDLE.
- Single-beat packets (valid and last in the same beat) are legal. The grant releases after that beat.
- out_ready low: out_data and out_last follow the owner's inputs unchanged. No state change, no counter change.
- grant is a direct decode of state and is never 11.
- The ready of a non-owner is never high.

Decomposition:
- Shared package mux_arb_pkg holds:
  - state enum/localparams ST_IDLE = 2'd0, ST_GNT0 = 2'd1, ST_GNT1 = 2'd2;
  - grant encodings GNT_NONE/GNT_0/GNT_1.
- Sub-module: the existing mux2_1, instantiated WIDTH + 1 times via generate (data bits plus last), with shared select.
- Valid and ready gating stays in the arbiter.

Test Plan:
- In0-only packet: after reset, in0 sends 3 beats A1, A2, A3 (last on A3) with out_ready = 1 -> grant = 01 from cycle 1; out_data = A1, A2, A3 on 3 consecutive cycles; pkt_cnt0 = 1; state returns to IDLE, grant = 00.
- Simultaneous request: both valid at the same cycle after reset, in0 with 2 beats and in1 with 2 beats -> in0 served first (prio = 0); in1 granted the cycle after in0's last beat with no bubble; pkt_cnt0 = pkt_cnt1 = 1.
- Backpressure: out_ready = 0 for 4 cycles mid-packet with data 0x5A held -> out_data = 0x5A and out_valid = 1 throughout; in0_ready = 0; no counter change; transfer resumes when out_ready = 1.
- Fairness: both requesters continuously valid with 1-beat packets for 8 transfers -> grant alternates 01, 10, 01, ...; final pkt_cnt0 = pkt_cnt1 = 4.
- Reset mid-packet: rst asserted asynchronously between clock edges during beat 2 of an in1 packet -> outputs go to 0 and grant = 00 immediately, without waiting for a clock edge; counters = 0; after release, a new in0 request is granted first.
- Counter wrap with CNT_W = 2: 5 single-beat in0 packets -> pkt_cnt0 sequence 1, 2, 3, 0, 1.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// Shared definitions for the two-requester packet arbiter.
// Holds the arbiter state encoding and the one-hot grant encodings so the
// top level and any future status logic agree on the same values.
package mux_arb_pkg;

  // Arbiter ownership states: nobody, requester 0 or requester 1.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2
  } arbState_t;

  // One-hot grant patterns presented on the grant port.
  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_0    = 2'b01;
  localparam logic [1:0] GNT_1    = 2'b10;

endpackage

// File: rtl/mux2_1.sv
// Single-bit 2:1 multiplexer cell.
// Ports:
//   zero_i - value passed when sel_i is 0
//   one_i  - value passed when sel_i is 1
//   sel_i  - select
//   y_o    - selected value
module mux2_1 (
  input  logic zero_i,
  input  logic one_i,
  input  logic sel_i,
  output logic y_o
);

  // Plain combinational select between the two inputs.
  assign y_o = sel_i ? one_i : zero_i;

endmodule

// File: rtl/mux2_1_arbiter.sv
// Round-robin, packet-locked arbiter sharing one stream sink between two
// stream sources. Ownership is granted per packet and only released on a
// transfer carrying the last flag; the priority pointer then flips so the
// other requester wins the next tie. Data and last are steered by a bank of
// mux2_1 cells whose shared select is driven by the current owner.
// Ports:
//   clk, rst                        - clock, asynchronous active-high reset
//   in0_valid/data/last, in0_ready  - requester 0 stream (maps to mux "zero")
//   in1_valid/data/last, in1_ready  - requester 1 stream (maps to mux "one")
//   out_valid/data/last, out_ready  - shared sink stream
//   grant                           - one-hot current owner (00 when idle)
//   pkt_cnt0, pkt_cnt1              - wrapping completed-packet counters
module mux2_1_arbiter
  import mux_arb_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in0_valid,
  input  logic [WIDTH-1:0] in0_data,
  input  logic             in0_last,
  output logic             in0_ready,
  input  logic             in1_valid,
  input  logic [WIDTH-1:0] in1_data,
  input  logic             in1_last,
  output logic             in1_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic [1:0]       grant,
  output logic [CNT_W-1:0] pkt_cnt0,
  output logic [CNT_W-1:0] pkt_cnt1
);

  arbState_t        state_q, state_d;
  logic             prio_q, prio_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  logic             muxSel;
  logic             ownerActive;
  logic [WIDTH:0]   muxZero;
  logic [WIDTH:0]   muxOne;
  logic [WIDTH:0]   muxOut;

  // The select only goes high while requester 1 owns the channel, so the
  // idle state naturally selects requester 0 before the output gating below.
  assign muxSel      = (state_q == ST_GNT1);
  assign ownerActive = (state_q != ST_IDLE);

  // Last flag rides on the top bit of each bus so one bank steers both.
  assign muxZero = {in0_last, in0_data};
  assign muxOne  = {in1_last, in1_data};

  // One mux cell per data bit plus one for the last flag, all sharing select.
  for (genvar i = 0; i <= WIDTH; i++) begin : gMuxBank
    mux2_1 uMux (
      .zero_i (muxZero[i]),
      .one_i  (muxOne[i]),
      .sel_i  (muxSel),
      .y_o    (muxOut[i])
    );
  end

  // Data and last are forced to zero while idle so the sink never sees a
  // stale requester-0 value without an owner behind it.
  assign out_data = ownerActive ? muxOut[WIDTH-1:0] : '0;
  assign out_last = ownerActive ? muxOut[WIDTH] : 1'b0;

  // Handshake gating: only the owner sees the sink's ready, and the sink only
  // sees the owner's valid. Everything is derived from the registered state,
  // so an asynchronous reset clears these immediately.
  always_comb begin
    out_valid = 1'b0;
    in0_ready = 1'b0;
    in1_ready = 1'b0;
    grant     = GNT_NONE;
    case (state_q)
      ST_GNT0: begin
        out_valid = in0_valid;
        in0_ready = out_ready;
        grant     = GNT_0;
      end
      ST_GNT1: begin
        out_valid = in1_valid;
        in1_ready = out_ready;
        grant     = GNT_1;
      end
      default: begin
        out_valid = 1'b0;
        grant     = GNT_NONE;
      end
    endcase
  end

  // Next-state logic. From idle the grant is decided one cycle ahead of the
  // first beat. An owner keeps the channel until its last beat transfers; at
  // that point the pointer flips and the other requester is handed the
  // channel directly if it is already waiting, otherwise we fall back to idle.
  // The finishing requester never keeps the grant, which enforces fairness.
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    cnt0_d  = cnt0_q;
    cnt1_d  = cnt1_q;
    case (state_q)
      ST_IDLE: begin
        if (in0_valid && in1_valid) begin
          state_d = prio_q ? ST_GNT1 : ST_GNT0;
        end else if (in0_valid) begin
          state_d = ST_GNT0;
        end else if (in1_valid) begin
          state_d = ST_GNT1;
        end
      end
      ST_GNT0: begin
        if (in0_valid && out_ready && in0_last) begin
          cnt0_d  = cnt0_q + CNT_W'(1);
          prio_d  = 1'b1;
          state_d = in1_valid ? ST_GNT1 : ST_IDLE;
        end
      end
      ST_GNT1: begin
        if (in1_valid && out_ready && in1_last) begin
          cnt1_d  = cnt1_q + CNT_W'(1);
          prio_d  = 1'b0;
          state_d = in0_valid ? ST_GNT0 : ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, priority pointer and counters. Reset abandons any packet in flight
  // and restores requester 0 as the preferred winner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      prio_q  <= 1'b0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
    end
  end

  assign pkt_cnt0 = cnt0_q;
  assign pkt_cnt1 = cnt1_q;

endmodule
